// File: rtl/parser_defs.sv
// Shared definitions for the order-message parser and serializer.
// This package holds the message record, the type and side codes, and the serializer state encoding.
package parser_defs;

   localparam int MSG_LENGTH    = 16;
   localparam int DELETE_LENGTH = 6;

   localparam logic [7:0] MSG_NULL   = 8'h00;
   localparam logic [7:0] MSG_ADD    = 8'h41;
   localparam logic [7:0] MSG_DELETE = 8'h44;
   localparam logic [7:0] MSG_EXEC   = 8'h45;

   localparam logic [7:0] ORDER_SIDE_BID     = 8'h42;
   localparam logic [7:0] ORDER_SIDE_ASK     = 8'h53;
   localparam logic [7:0] ORDER_SIDE_UNKNOWN = 8'h3F;

   // Field order matches the wire order, most significant field first.
   typedef struct packed {
      logic [7:0]  msg_type;
      logic [7:0]  stock_id;
      logic [31:0] order_id;
      logic [7:0]  order_side;
      logic [31:0] price;
      logic [31:0] quantity;
      logic [7:0]  padding;
   } parsed_msg_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } ser_state_t;

   function automatic logic [3:0] last_index(input logic [7:0] msg_type);
      return (msg_type == MSG_DELETE) ? 4'(DELETE_LENGTH - 1) : 4'(MSG_LENGTH - 1);
   endfunction

endpackage

// File: rtl/msg_byte_mux.sv
// Selects the wire byte for a given index from a captured message.
// This module is purely combinational; byte order follows the wire format with multi-byte fields MSB first.
module msg_byte_mux
   import parser_defs::*;
(
   input  parsed_msg_t msg_i,
   input  logic [3:0]  idx_i,
   output logic [7:0]  byte_o
);

   always_comb begin
      byte_o = 8'h00;
      case (idx_i)
         4'd0:    byte_o = msg_i.msg_type;
         4'd1:    byte_o = msg_i.stock_id;
         4'd2:    byte_o = msg_i.order_id[31:24];
         4'd3:    byte_o = msg_i.order_id[23:16];
         4'd4:    byte_o = msg_i.order_id[15:8];
         4'd5:    byte_o = msg_i.order_id[7:0];
         4'd6:    byte_o = msg_i.order_side;
         4'd7:    byte_o = msg_i.price[31:24];
         4'd8:    byte_o = msg_i.price[23:16];
         4'd9:    byte_o = msg_i.price[15:8];
         4'd10:   byte_o = msg_i.price[7:0];
         4'd11:   byte_o = msg_i.quantity[31:24];
         4'd12:   byte_o = msg_i.quantity[23:16];
         4'd13:   byte_o = msg_i.quantity[15:8];
         4'd14:   byte_o = msg_i.quantity[7:0];
         4'd15:   byte_o = msg_i.padding;
         default: byte_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/msg_serializer.sv
// Turns one parsed message into a valid/ready byte stream, with an optional idle gap between messages.
//   state | meaning
//   IDLE  | waiting for msg_valid; msg_ready high
//   SEND  | presenting bytes of the captured message, index advances on acceptance
//   GAP   | enforced idle cycles after a message, counted down from GAP_CYCLES-1
module msg_serializer
   import parser_defs::*;
#(
   parameter int GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  parsed_msg_t msg_in,
   input  logic        msg_valid,
   output logic        msg_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        byte_last,
   output logic        done
);

   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   ser_state_t  state_q;
   logic [3:0]  idx_q;
   logic [3:0]  gap_q;
   parsed_msg_t msg_q;
   logic        byte_valid_q;
   logic        done_q;
   logic [7:0]  byte_sel;
   logic [3:0]  last_idx;
   logic        at_last;

   msg_byte_mux u_byte_mux (
      .msg_i  (msg_q),
      .idx_i  (idx_q),
      .byte_o (byte_sel)
   );

   assign last_idx   = last_index(msg_q.msg_type);
   assign at_last    = (idx_q == last_idx);
   assign msg_ready  = (state_q == IDLE) && !reset;
   assign byte_valid = byte_valid_q;
   // Gate on valid so the bus reads zero whenever nothing is being offered.
   assign byte_out   = byte_valid_q ? byte_sel : 8'h00;
   assign byte_last  = byte_valid_q && at_last;
   assign done       = done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= 4'd0;
         gap_q        <= 4'd0;
         msg_q        <= '0;
         byte_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (msg_valid && msg_ready) begin
                  msg_q        <= msg_in;
                  idx_q        <= 4'd0;
                  byte_valid_q <= 1'b1;
                  state_q      <= SEND;
               end
            end
            SEND: begin
               if (byte_ready) begin
                  if (at_last) begin
                     byte_valid_q <= 1'b0;
                     done_q       <= 1'b1;
                     idx_q        <= 4'd0;
                     if (GAP_CYCLES > 0) begin
                        gap_q   <= GAP_LOAD;
                        state_q <= GAP;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            GAP: begin
               if (gap_q == 4'd0) begin
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            default: begin
               state_q      <= IDLE;
               byte_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_serializer.sv
// Self-checking bench for msg_serializer: directed vector table, backpressure, back-to-back,
// mid-message reset and randomized loopback through a behavioural byte-stream parser.
module tb_msg_serializer;
   import parser_defs::*;

   typedef logic [7:0] byte_q_t [$];

   typedef struct {
      parsed_msg_t   msg;
      int            exp_len;
      logic [127:0]  exp_bytes;
   } vec_t;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        reset;
   logic [1:0]        msg_valid;
   logic [1:0]        byte_ready;
   parsed_msg_t [1:0] msg_in;
   wire  [1:0]        msg_ready;
   wire  [1:0]        byte_valid;
   wire  [1:0]        byte_last;
   wire  [1:0]        done;
   wire  [1:0][7:0]   byte_out;

   int n_tests = 0;
   int n_fail  = 0;

   msg_serializer #(.GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset[0]), .msg_in(msg_in[0]), .msg_valid(msg_valid[0]),
      .msg_ready(msg_ready[0]), .byte_out(byte_out[0]), .byte_valid(byte_valid[0]),
      .byte_ready(byte_ready[0]), .byte_last(byte_last[0]), .done(done[0])
   );

   msg_serializer #(.GAP_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset[1]), .msg_in(msg_in[1]), .msg_valid(msg_valid[1]),
      .msg_ready(msg_ready[1]), .byte_out(byte_out[1]), .byte_valid(byte_valid[1]),
      .byte_ready(byte_ready[1]), .byte_last(byte_last[1]), .done(done[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference wire image: fields laid out in transmit order, truncated for deletes.
   function automatic void model_bytes(input parsed_msg_t m, output byte_q_t q);
      logic [127:0] flat;
      int len;
      flat = {m.msg_type, m.stock_id, m.order_id, m.order_side, m.price, m.quantity, m.padding};
      len  = (m.msg_type == MSG_DELETE) ? DELETE_LENGTH : MSG_LENGTH;
      q = {};
      for (int i = 0; i < len; i++) q.push_back(flat[127 - 8*i -: 8]);
   endfunction

   function automatic parsed_msg_t rand_msg();
      parsed_msg_t m;
      int r;
      m.stock_id = 8'($urandom);
      m.order_id = $urandom;
      m.price    = $urandom;
      m.quantity = $urandom;
      m.padding  = 8'($urandom);
      r = $urandom_range(0, 2);
      m.order_side = (r == 0) ? ORDER_SIDE_BID : (r == 1) ? ORDER_SIDE_ASK : ORDER_SIDE_UNKNOWN;
      r = $urandom_range(0, 4);
      case (r)
         0:       m.msg_type = MSG_ADD;
         1:       m.msg_type = MSG_DELETE;
         2:       m.msg_type = MSG_NULL;
         3:       m.msg_type = MSG_EXEC;
         default: m.msg_type = 8'($urandom);
      endcase
      return m;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++)
         chk("last_implies_valid", 64'(byte_last[d] & ~byte_valid[d]), 64'd0);
   end

   // Sends one message, optionally stalling byte_ready for stall_len cycles when byte stall_at is offered.
   // Returns in the cycle after the final byte was accepted (the expected done cycle).
   task automatic run_msg(input int d, input parsed_msg_t m, input int stall_at, input int stall_len,
                          output byte_q_t got, output logic [15:0] lastv, output int vcyc,
                          output logic done_seen);
      int guard;
      int stall_left;
      logic hold;
      logic [7:0] held;
      logic fin;
      got = {};
      lastv = '0;
      vcyc = 0;
      done_seen = 1'b0;
      stall_left = stall_len;
      hold = 1'b0;
      held = 8'h00;
      fin = 1'b0;
      msg_in[d] = m;
      msg_valid[d] = 1'b1;
      byte_ready[d] = 1'b1;
      guard = 0;
      #1;
      while (!msg_ready[d] && guard < 40) begin
         tick();
         guard++;
      end
      chk("accept_wait", 64'(msg_ready[d]), 64'd1);
      tick();
      msg_valid[d] = 1'b0;
      msg_in[d] = rand_msg();
      chk("first_byte_latency", 64'(byte_valid[d]), 64'd1);
      chk("ready_low_in_send", 64'(msg_ready[d]), 64'd0);
      guard = 0;
      while (!fin && guard < 100) begin
         if (hold) begin
            chk("hold_stable", 64'({byte_valid[d], byte_out[d]}), 64'({1'b1, held}));
            hold = 1'b0;
         end
         if (byte_valid[d]) vcyc++;
         if (got.size() == stall_at && stall_left > 0) begin
            byte_ready[d] = 1'b0;
            stall_left--;
            hold = byte_valid[d];
            held = byte_out[d];
         end else begin
            byte_ready[d] = 1'b1;
         end
         if (byte_valid[d] && byte_ready[d]) begin
            if (got.size() < 16) lastv[4'(got.size())] = byte_last[d];
            got.push_back(byte_out[d]);
            fin = byte_last[d];
         end
         tick();
         guard++;
      end
      chk("msg_terminated", 64'(fin), 64'd1);
      done_seen = done[d];
      byte_ready[d] = 1'b1;
   endtask

   // msg_valid held high across two messages; measures cycles from the first done to the second byte 0.
   task automatic back_to_back(input int d, input parsed_msg_t m1, input parsed_msg_t m2, input int exp_gap);
      int k;
      msg_in[d] = m1;
      msg_valid[d] = 1'b1;
      byte_ready[d] = 1'b1;
      k = 0;
      #1;
      while (!byte_valid[d] && k < 40) begin tick(); k++; end
      msg_in[d] = m2;
      k = 0;
      while (!done[d] && k < 40) begin tick(); k++; end
      chk("b2b_done_seen", 64'(done[d]), 64'd1);
      if (d == 0) chk("b2b_ready_in_done", 64'(msg_ready[d]), 64'd1);
      k = 0;
      while (!byte_valid[d] && k < 20) begin tick(); k++; end
      chk("b2b_gap_cycles", 64'(k), 64'(exp_gap));
      chk("b2b_second_byte0", 64'(byte_out[d]), 64'(m2.msg_type));
      msg_valid[d] = 1'b0;
      k = 0;
      while (!done[d] && k < 40) begin tick(); k++; end
      chk("b2b_second_done", 64'(done[d]), 64'd1);
   endtask

   vec_t        vecs [4];
   byte_q_t     got;
   byte_q_t     expq;
   logic [15:0] lastv;
   int          vcyc;
   logic        ds;
   int          cnt;
   int          exp_len;
   parsed_msg_t rm;
   logic [31:0] w;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0].msg = '{msg_type: MSG_ADD, stock_id: 8'h07, order_id: 32'h01020304,
                      order_side: ORDER_SIDE_BID, price: 32'h00001388, quantity: 32'h00000064,
                      padding: 8'hA5};
      vecs[0].exp_len = 16;
      vecs[0].exp_bytes = 128'h41_07_01020304_42_00001388_00000064_A5;
      vecs[1].msg = '{msg_type: MSG_DELETE, stock_id: 8'h11, order_id: 32'hDEADBEEF,
                      order_side: ORDER_SIDE_ASK, price: 32'h12345678, quantity: 32'h9ABCDEF0,
                      padding: 8'h77};
      vecs[1].exp_len = 6;
      vecs[1].exp_bytes = 128'h44_11_DEADBEEF_00000000000000000000;
      vecs[2].msg = '{msg_type: MSG_NULL, stock_id: 8'hFF, order_id: 32'hCAFEF00D,
                      order_side: ORDER_SIDE_UNKNOWN, price: 32'hFFFFFFFF, quantity: 32'h00000001,
                      padding: 8'h00};
      vecs[2].exp_len = 16;
      vecs[2].exp_bytes = 128'h00_FF_CAFEF00D_3F_FFFFFFFF_00000001_00;
      vecs[3].msg = '{msg_type: 8'h7E, stock_id: 8'h80, order_id: 32'h00000000,
                      order_side: ORDER_SIDE_ASK, price: 32'h80000000, quantity: 32'h7FFFFFFF,
                      padding: 8'hC3};
      vecs[3].exp_len = 16;
      vecs[3].exp_bytes = 128'h7E_80_00000000_53_80000000_7FFFFFFF_C3;

      reset = 2'b11;
      msg_valid = 2'b00;
      byte_ready = 2'b11;
      msg_in[0] = vecs[0].msg;
      msg_in[1] = vecs[1].msg;
      msg_valid = 2'b11;
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         chk("rst_byte_valid", 64'(byte_valid[d]), 64'd0);
         chk("rst_byte_out",   64'(byte_out[d]),   64'd0);
         chk("rst_byte_last",  64'(byte_last[d]),  64'd0);
         chk("rst_done",       64'(done[d]),       64'd0);
         chk("rst_msg_ready",  64'(msg_ready[d]),  64'd0);
      end
      msg_valid = 2'b00;
      reset = 2'b00;
      #1;
      chk("ready_after_rst0", 64'(msg_ready[0]), 64'd1);
      chk("ready_after_rst3", 64'(msg_ready[1]), 64'd1);

      // Directed vector table.
      for (int v = 0; v < 4; v++) begin
         run_msg(0, vecs[v].msg, -1, 0, got, lastv, vcyc, ds);
         chk("vec_len", 64'(got.size()), 64'(vecs[v].exp_len));
         for (int i = 0; i < vecs[v].exp_len && i < got.size(); i++)
            chk("vec_byte", 64'(got[i]), 64'(vecs[v].exp_bytes[127 - 8*i -: 8]));
         chk("vec_last_pos", 64'(lastv), 64'(16'd1 << (vecs[v].exp_len - 1)));
         chk("vec_one_per_cycle", 64'(vcyc), 64'(vecs[v].exp_len));
         chk("vec_done", 64'(ds), 64'd1);
         chk("vec_valid_off_in_done", 64'(byte_valid[0]), 64'd0);
         tick();
         chk("vec_done_one_cycle", 64'(done[0]), 64'd0);
      end

      // Backpressure: three stalled cycles while price MSB-1 byte (index 8) is offered.
      run_msg(0, vecs[0].msg, 8, 3, got, lastv, vcyc, ds);
      model_bytes(vecs[0].msg, expq);
      chk("bp_valid_cycles", 64'(vcyc), 64'd19);
      chk("bp_len", 64'(got.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         chk("bp_byte", 64'(got[i]), 64'(expq[i]));
      chk("bp_done", 64'(ds), 64'd1);
      tick();

      back_to_back(0, vecs[0].msg, vecs[3].msg, 1);
      back_to_back(1, vecs[0].msg, vecs[2].msg, 4);

      // Reset while byte 9 is on the bus.
      tick();
      msg_in[0] = vecs[0].msg;
      msg_valid[0] = 1'b1;
      byte_ready[0] = 1'b1;
      cnt = 0;
      #1;
      while (!msg_ready[0] && cnt < 40) begin tick(); cnt++; end
      tick();
      msg_valid[0] = 1'b0;
      repeat (9) tick();
      chk("rstmid_byte9", 64'({byte_valid[0], byte_out[0]}), 64'({1'b1, 8'h13}));
      reset[0] = 1'b1;
      #1;
      chk("rstmid_ready_low", 64'(msg_ready[0]), 64'd0);
      tick();
      chk("rstmid_valid_off", 64'(byte_valid[0]), 64'd0);
      chk("rstmid_out_zero",  64'(byte_out[0]),   64'd0);
      chk("rstmid_no_done",   64'(done[0]),       64'd0);
      reset[0] = 1'b0;
      #1;
      chk("rstmid_ready_after", 64'(msg_ready[0]), 64'd1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (byte_valid[0] || done[0]) cnt++;
         tick();
      end
      chk("rstmid_no_residue", 64'(cnt), 64'd0);
      run_msg(0, vecs[2].msg, -1, 0, got, lastv, vcyc, ds);
      model_bytes(vecs[2].msg, expq);
      chk("rstmid_next_len", 64'(got.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         chk("rstmid_next_byte", 64'(got[i]), 64'(expq[i]));

      // Randomized loopback: reassemble the stream into fields and compare with what was sent.
      for (int k = 0; k < 100; k++) begin
         rm = rand_msg();
         run_msg(k % 2, rm, $urandom_range(0, 16), $urandom_range(0, 3), got, lastv, vcyc, ds);
         exp_len = (rm.msg_type == MSG_DELETE) ? DELETE_LENGTH : MSG_LENGTH;
         chk("lb_len", 64'(got.size()), 64'(exp_len));
         chk("lb_done", 64'(ds), 64'd1);
         chk("lb_last_pos", 64'(lastv), 64'(16'd1 << (exp_len - 1)));
         if (got.size() == exp_len) begin
            chk("lb_type",  64'(got[0]), 64'(rm.msg_type));
            chk("lb_stock", 64'(got[1]), 64'(rm.stock_id));
            w = {got[2], got[3], got[4], got[5]};
            chk("lb_order_id", 64'(w), 64'(rm.order_id));
            if (exp_len == MSG_LENGTH) begin
               chk("lb_side", 64'(got[6]), 64'(rm.order_side));
               w = {got[7], got[8], got[9], got[10]};
               chk("lb_price", 64'(w), 64'(rm.price));
               w = {got[11], got[12], got[13], got[14]};
               chk("lb_qty", 64'(w), 64'(rm.quantity));
               chk("lb_pad", 64'(got[15]), 64'(rm.padding));
            end
         end
      end

      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
